combination_lock_cracker: RTL and testbench
===========================================

Name: combination_lock_cracker

Overview:
Upstream sequencer for the combination lock dial stage. It sweeps a 4-bit guess through 0..DIGIT_MAX for each digit position, holds each guess for a fixed dwell time, and samples the dial's digit_found_flag. It records the matching digit and advances to the next position, reporting the recovered combination or a failure. One dial per position sits downstream; an external mux returns the flag of the dial selected by digit_index.

Parameters:
NUM_DIGITS, 4, number of combination positions (1..8)
DWELL_CYCLES, 4, clock cycles each guess is held before the flag is sampled (>=1)
DIGIT_MAX, 9, highest guess value tried per position (0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a run
abort  input  1  stops an active run
digit_found_flag  input  1  match flag from the dial selected by digit_index
combination_digit_guess  output  4  registered guess driven to the dials
digit_index  output  3  position currently being searched (0..NUM_DIGITS-1)
cracked_code  output  4*NUM_DIGITS  recovered digits; position i at bits [4i+3:4i]
busy  output  1  high while a run is active
done  output  1  sticky; all positions matched
fail  output  1  sticky; some position had no match in 0..DIGIT_MAX
attempt_count  output  8  guesses sampled in the current run, saturating at 255

Behaviour:
- Reset: guess=0, digit_index=0, cracked_code=0, busy=0, done=0, fail=0, attempt_count=0, dwell counter=0, state=IDLE.
- States: IDLE, SWEEP, DONE, FAIL.
- IDLE/DONE/FAIL with start=1 at an edge:
  - Next cycle: SWEEP, busy=1, guess=0, digit_index=0, dwell=0.
  - cracked_code, attempt_count, done and fail are cleared.
- start while in SWEEP is ignored.
- SWEEP, each edge:
  - If dwell < DWELL_CYCLES-1: dwell increments. Guess and index are held.
  - If dwell == DWELL_CYCLES-1, this is a sample edge:
    - attempt_count increments (saturating) and dwell returns to 0.
    - flag=1: write guess into slot digit_index of cracked_code.
      - If digit_index == NUM_DIGITS-1: go to DONE; busy=0, done=1.
      - Otherwise: digit_index increments and guess returns to 0.
    - flag=0 and guess < DIGIT_MAX: guess increments.
    - flag=0 and guess == DIGIT_MAX: go to FAIL; busy=0, fail=1. Guess and index hold their last values.
- The flag is sampled only on sample edges. Its value on other cycles is ignored, which masks glitches from the combinational dial while the guess settles.
- Each guess value is presented for exactly DWELL_CYCLES cycles.
- Latency: for combination digits d_i, done rises sum over i of (d_i+1)*DWELL_CYCLES cycles after the start edge. The final attempt_count is sum over i of (d_i+1).
- Abort:
  - abort=1 in SWEEP: next state IDLE, busy=0, guess=0, digit_index=0.
  - cracked_code and attempt_count keep their partial values; done and fail stay 0.
  - abort outside SWEEP has no effect.
- Simultaneous abort and sample edge: abort wins. No slot is written and done/fail are not set.
- Simultaneous start and abort in IDLE/DONE/FAIL: start wins.
- rst at any time, including mid-run, forces all reset values on that edge.

Test Plan:
- Combination 3-0-9-1, DWELL_CYCLES=4, start pulse -> done=1 exactly 68 cycles after the start edge; cracked_code=16'h1903; attempt_count=17; busy low from the same edge; fail=0.
- Combination 0-0-0-0 -> done after 16 cycles; cracked_code=0; attempt_count=4; guess never exceeds 0.
- Position 2 combination digit=12 with DIGIT_MAX=9, others 5 -> fail=1 after (6+6+10)*4=88 cycles; digit_index=2; guess=9; cracked_code[7:0]=8'h55; done=0.
- Flag pulsed high on a non-sample cycle of the wrong guess -> no advance; the pulse is ignored and the correct result is still found.
- abort asserted on the 3rd sample edge of a run -> IDLE next cycle; busy=0; no slot written on that edge; attempt_count=2; a new start then completes normally.
- rst asserted mid-SWEEP, then start asserted during DONE -> all outputs return to reset values; on restart done clears, cracked_code clears and the run repeats with identical timing.

Source files
------------

// File: rtl/combination_lock_cracker_if.sv
// Handshake and result bundle between the lock cracker sequencer and its dials/consumer.
// The master side is the sequencer; the slave side drives control and the muxed dial flag.
interface combination_lock_cracker_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    start;
    logic                    abort;
    logic                    digit_found_flag;
    logic [3:0]              combination_digit_guess;
    logic [2:0]              digit_index;
    logic [4*NUM_DIGITS-1:0] cracked_code;
    logic                    busy;
    logic                    done;
    logic                    fail;
    logic [7:0]              attempt_count;

    modport master (
        input  start,
        input  abort,
        input  digit_found_flag,
        output combination_digit_guess,
        output digit_index,
        output cracked_code,
        output busy,
        output done,
        output fail,
        output attempt_count
    );

    modport slave (
        output start,
        output abort,
        output digit_found_flag,
        input  combination_digit_guess,
        input  digit_index,
        input  cracked_code,
        input  busy,
        input  done,
        input  fail,
        input  attempt_count
    );
endinterface

// File: rtl/combination_lock_cracker.sv
// Sweeps a guess per position, holds it for a fixed dwell, samples the dial flag on the
// last dwell cycle and assembles the recovered combination.
module combination_lock_cracker #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned DIGIT_MAX    = 9
) (
    input logic                        clk,
    input logic                        rst,
    combination_lock_cracker_if.master bus
);
    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]    GUESS_MAX  = 4'(DIGIT_MAX);

    typedef enum logic [1:0] {StIdle, StSweep, StDone, StFail} state_e;

    state_e                  state_q;
    logic [DW-1:0]           dwell_q;
    logic [3:0]              guess_q;
    logic [2:0]              idx_q;
    logic [4*NUM_DIGITS-1:0] code_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    fail_q;
    logic [7:0]              attempt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            dwell_q   <= '0;
            guess_q   <= '0;
            idx_q     <= '0;
            code_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            attempt_q <= '0;
        end else begin
            unique case (state_q)
                StSweep: begin
                    // Abort takes priority over a coincident sample edge.
                    if (bus.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        guess_q <= '0;
                        idx_q   <= '0;
                        dwell_q <= '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (attempt_q != 8'hff) begin
                            attempt_q <= attempt_q + 8'd1;
                        end
                        if (bus.digit_found_flag) begin
                            code_q[{idx_q, 2'b00} +: 4] <= guess_q;
                            if (idx_q == LAST_IDX) begin
                                state_q <= StDone;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q   <= idx_q + 3'd1;
                                guess_q <= '0;
                            end
                        end else if (guess_q == GUESS_MAX) begin
                            state_q <= StFail;
                            busy_q  <= 1'b0;
                            fail_q  <= 1'b1;
                        end else begin
                            guess_q <= guess_q + 4'd1;
                        end
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end
                default: begin
                    if (bus.start) begin
                        state_q   <= StSweep;
                        busy_q    <= 1'b1;
                        guess_q   <= '0;
                        idx_q     <= '0;
                        dwell_q   <= '0;
                        code_q    <= '0;
                        attempt_q <= '0;
                        done_q    <= 1'b0;
                        fail_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.combination_digit_guess = guess_q;
    assign bus.digit_index             = idx_q;
    assign bus.cracked_code            = code_q;
    assign bus.busy                    = busy_q;
    assign bus.done                    = done_q;
    assign bus.fail                    = fail_q;
    assign bus.attempt_count           = attempt_q;
endmodule

// File: tb/tb_combination_lock_cracker.sv
// Randomized bench for the lock cracker: a dial model answers guesses, and a position-by-position
// search model predicts the final code, attempts, latency and terminal state of every run.
module tb_combination_lock_cracker;
    localparam int N    = 4;
    localparam int DWL  = 4;
    localparam int DMAX = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic glitch = 1'b0;
    logic [3:0] comb [0:7];

    int n_chk = 0;
    int n_bad = 0;

    int          exp_att;
    logic [15:0] exp_code;
    bit          exp_done;
    bit          exp_fail;
    int          exp_idx;
    int          exp_guess;
    int          exp_maxg;

    always #5 clk = ~clk;

    combination_lock_cracker_if #(.NUM_DIGITS(N)) bus ();

    combination_lock_cracker #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(DWL),
        .DIGIT_MAX   (DMAX)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Downstream dial bank: the selected dial flags when the guess matches its digit.
    assign bus.digit_found_flag = glitch | (bus.combination_digit_guess == comb[bus.digit_index]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Guess 0..DMAX at each position in turn; only the first max_samples guesses take effect.
    task automatic model(input int max_samples);
        bit stop;
        bit found;
        exp_att = 0; exp_code = '0; exp_done = 0; exp_fail = 0;
        exp_idx = 0; exp_guess = 0; exp_maxg = 0; stop = 0;
        for (int p = 0; p < N; p++) begin
            found = 0;
            for (int g = 0; g <= DMAX; g++) begin
                if (exp_att == max_samples) begin
                    stop = 1;
                    break;
                end
                exp_att++;
                exp_idx = p;
                exp_guess = g;
                if (g > exp_maxg) exp_maxg = g;
                if (comb[p] == 4'(g)) begin
                    found = 1;
                    break;
                end
            end
            if (stop) break;
            if (!found) begin
                exp_fail = 1;
                break;
            end
            exp_code[p*4 +: 4] = comb[p];
            if (p == N - 1) begin
                exp_done = 1;
            end else begin
                exp_idx = p + 1;
                exp_guess = 0;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_fail"}, bus.fail, 0);
        check({tag, "_guess"}, bus.combination_digit_guess, 0);
        check({tag, "_idx"}, bus.digit_index, 0);
        check({tag, "_code"}, bus.cracked_code, 0);
        check({tag, "_att"}, bus.attempt_count, 0);
    endtask

    // One run from a start pulse; gl adds flag glitches and stray starts on non-sample cycles,
    // abort_at > 0 raises abort on that sample edge.
    task automatic run(input string tag, input bit gl, input int abort_at);
        int n;
        int maxg;
        bit ended;
        model((abort_at > 0) ? abort_at - 1 : 100000);
        if (abort_at > 0) begin
            exp_idx = 0;
            exp_guess = 0;
        end
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        n = 0; maxg = 0; ended = 0;
        while (!ended && n < 400) begin
            @(negedge clk);
            bus.start = gl && (n > 0) && ($urandom_range(0, 7) == 0);
            bus.abort = (abort_at > 0) && (n + 1 == abort_at * DWL);
            glitch = gl && ((n + 1) % DWL != 0) && ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1;
            n++;
            if (int'(bus.combination_digit_guess) > maxg) maxg = int'(bus.combination_digit_guess);
            if (n == 1) begin
                check({tag, "_run_busy"}, bus.busy, 1);
                check({tag, "_run_done_clr"}, bus.done, 0);
                check({tag, "_run_code_clr"}, bus.cracked_code, 0);
                check({tag, "_run_att_clr"}, bus.attempt_count, 0);
            end
            if (abort_at > 0) ended = (n == abort_at * DWL);
            else ended = bus.done || bus.fail;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        glitch = 1'b0;
        check({tag, "_ended"}, ended, 1);
        if (abort_at == 0) check({tag, "_latency"}, n, exp_att * DWL);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, exp_done);
        check({tag, "_fail"}, bus.fail, exp_fail);
        check({tag, "_code"}, bus.cracked_code, exp_code);
        check({tag, "_att"}, bus.attempt_count, exp_att);
        check({tag, "_idx"}, bus.digit_index, exp_idx);
        check({tag, "_guess"}, bus.combination_digit_guess, exp_guess);
        check({tag, "_maxg"}, maxg, exp_maxg);
    endtask

    task automatic set_comb(input int d0, input int d1, input int d2, input int d3);
        for (int p = 0; p < 8; p++) comb[p] = 4'd0;
        comb[0] = 4'(d0); comb[1] = 4'(d1); comb[2] = 4'(d2); comb[3] = 4'(d3);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_comb(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        set_comb(3, 0, 9, 1);
        run("c3091", 0, 0);
        set_comb(0, 0, 0, 0);
        run("c0000", 0, 0);
        set_comb(5, 5, 12, 5);
        run("nomatch", 0, 0);
        set_comb(3, 0, 9, 1);
        run("glitch", 1, 0);
        set_comb(1, 0, 4, 2);
        run("abort", 0, 3);
        run("after_abort", 0, 0);

        // Abort outside a run must leave the sticky result alone.
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        check("idle_abort_done", bus.done, 1);
        check("idle_abort_code", bus.cracked_code, exp_code);
        @(negedge clk);
        bus.abort = 1'b0;

        // Reset mid-sweep, then restart twice; the second start lands in the done state.
        set_comb(7, 2, 8, 6);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        run("rst_run1", 0, 0);
        run("rst_run2", 0, 0);

        for (int r = 0; r < 10; r++) begin
            for (int p = 0; p < N; p++) comb[p] = 4'($urandom_range(0, 11));
            run($sformatf("rnd%0d", r), 1, 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
